fifo_mlab_thresh: RTL and testbench

- Parametrised single-clock FIFO for buffering between CPU-side pipeline stages and memory/IO interfaces.
- Generalises the team's simple MLAB FIFO with:
  - full-range fill count
  - programmable almost-full and almost-empty thresholds
  - selectable show-ahead or registered-read output mode
  - optional sticky overflow/underflow error flags
- Storage is a behavioural memory array, intended to infer MLAB/LUTRAM.

---
 rtl/fifo_mlab_thresh.sv | 118 +++++++++++
 tb/tb_fifo_mlab_thresh.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mlab_thresh.sv
// rtl/fifo_mlab_thresh.sv - single-clock MLAB FIFO with fill count, thresholds and show-ahead/registered read
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_mlab_thresh #(
  parameter int WIDTH        = 8,
  parameter int WIDTHU       = 4,
  parameter int AFULL_LEVEL  = 2**WIDTHU-2,
  parameter int AEMPTY_LEVEL = 1,
  parameter bit SHOWAHEAD    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [WIDTHU:0]  usedw
);

  localparam int DEPTH = 2**WIDTHU;
  localparam logic [WIDTHU:0] DEPTH_C  = DEPTH[WIDTHU:0];
  localparam logic [WIDTHU:0] AFULL_C  = AFULL_LEVEL[WIDTHU:0];
  localparam logic [WIDTHU:0] AEMPTY_C = AEMPTY_LEVEL[WIDTHU:0];

  // Thresholds must be ordered and fit inside the fill-count range.
  if (WIDTHU < 1 || AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= AFULL_LEVEL || AFULL_LEVEL > DEPTH) begin : g_param_check
    $error("fifo_mlab_thresh: illegal parameters (need 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH, WIDTHU >= 1)");
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTHU-1:0] rd_ptr;
  logic [WIDTHU-1:0] wr_ptr;
  logic [WIDTHU:0]   count;
  logic              rd_en;
  logic              wr_en;

  // Status flags decode the registered count, so they move together with usedw.
  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_empty = (count <= AEMPTY_C);
    almost_full  = (count >= AFULL_C);
    usedw        = count;
  end

  // A read frees a slot when full, so a paired write is still accepted; sclr masks both.
  always_comb begin
    rd_en = rdreq & ~empty & ~sclr;
    wr_en = wrreq & (~full | rdreq) & ~sclr;
  end

  // Pointer and fill-count state; pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (sclr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array without reset so it maps onto MLAB/LUTRAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  generate
    if (SHOWAHEAD) begin : g_showahead
      // Head entry is presented asynchronously; meaningless while empty.
      always_comb begin
        q = mem[rd_ptr];
      end
    end else begin : g_registered
      // Registered read port: captures the head word only on an accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (sclr)  q <= '0;
        else if (rd_en) q <= mem[rd_ptr];
      end
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags for requests the FIFO had to reject; only reset or sclr clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sclr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrreq & full & ~rdreq)   overflow  <= 1'b1;
      if (rdreq & empty & ~wrreq)  underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_mlab_thresh.sv
// tb/tb_fifo_mlab_thresh.sv - self-checking bench for fifo_mlab_thresh, show-ahead and registered instances
module tb_fifo_mlab_thresh;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       sclr;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] data;

  logic [7:0] q_sa, q_rg;
  logic       emp_sa, ful_sa, ae_sa, af_sa;
  logic       emp_rg, ful_rg, ae_rg, af_rg;
  logic [2:0] uw_sa, uw_rg;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf_sa, unf_sa, ovf_rg, unf_rg;
`endif

  fifo_mlab_thresh #(.WIDTH(8), .WIDTHU(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .SHOWAHEAD(1'b1)) dut_sa (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q_sa), .empty(emp_sa), .full(ful_sa), .almost_empty(ae_sa), .almost_full(af_sa),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(ovf_sa), .underflow(unf_sa),
`endif
    .usedw(uw_sa)
  );

  fifo_mlab_thresh #(.WIDTH(8), .WIDTHU(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .SHOWAHEAD(1'b0)) dut_rg (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q_rg), .empty(emp_rg), .full(ful_rg), .almost_empty(ae_rg), .almost_full(af_rg),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(ovf_rg), .underflow(unf_rg),
`endif
    .usedw(uw_rg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, registered read word, sticky flags.
  logic [7:0] mq[$];
  logic [7:0] m_rq;
  bit         m_ovf, m_unf;
  bit         chk_on;
  int         n_chk, n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    m_rq  = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of stimulus; model advances at the same edge from the same inputs.
  task automatic step(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
    int n;
    wrreq = wr; rdreq = rd; data = d; sclr = clr;
    @(posedge clk);
    n = mq.size();
    if (clr) begin
      model_clear();
    end else begin
      if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && n == 0 && !wr)     m_unf = 1'b1;
      if (rd && n > 0)             m_rq = mq.pop_front();
      if (wr && (n < DEPTH || rd)) mq.push_back(d);
    end
    #1;
    wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sa_usedw", 32'(uw_sa), mq.size());
      chk("sa_empty", 32'(emp_sa), 32'(mq.size() == 0));
      chk("sa_full",  32'(ful_sa), 32'(mq.size() == DEPTH));
      chk("sa_aempty", 32'(ae_sa), 32'(mq.size() <= 1));
      chk("sa_afull", 32'(af_sa), 32'(mq.size() >= 3));
      if (mq.size() != 0) chk("sa_q", 32'(q_sa), 32'(mq[0]));
      chk("rg_usedw", 32'(uw_rg), mq.size());
      chk("rg_empty", 32'(emp_rg), 32'(mq.size() == 0));
      chk("rg_full",  32'(ful_rg), 32'(mq.size() == DEPTH));
      chk("rg_aempty", 32'(ae_rg), 32'(mq.size() <= 1));
      chk("rg_afull", 32'(af_rg), 32'(mq.size() >= 3));
      chk("rg_q", 32'(q_rg), 32'(m_rq));
`ifdef FIFO_ERR_FLAGS_EN
      chk("sa_overflow", 32'(ovf_sa), 32'(m_ovf));
      chk("sa_underflow", 32'(unf_sa), 32'(m_unf));
      chk("rg_overflow", 32'(ovf_rg), 32'(m_ovf));
      chk("rg_underflow", 32'(unf_rg), 32'(m_unf));
`endif
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; chk_on = 1'b0;
    rst_n = 1'b0; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_empty", 32'(emp_sa), 1);
    chk("rst_full", 32'(ful_sa), 0);
    chk("rst_aempty", 32'(ae_sa), 1);
    chk("rst_afull", 32'(af_sa), 0);
    chk("rst_usedw", 32'(uw_sa), 0);
    chk("rst_rg_q", 32'(q_rg), 0);
    chk_on = 1'b1;

    // Fill 0x11..0x44
    step(1, 0, 8'h11, 0);
    chk("w1_usedw", 32'(uw_sa), 1);
    chk("w1_q_sa", 32'(q_sa), 'h11);
    chk("w1_q_rg", 32'(q_rg), 0);
    step(1, 0, 8'h22, 0);
    chk("w2_usedw", 32'(uw_sa), 2);
    chk("w2_afull", 32'(af_sa), 0);
    step(1, 0, 8'h33, 0);
    chk("w3_usedw", 32'(uw_sa), 3);
    chk("w3_afull", 32'(af_sa), 1);
    chk("w3_full", 32'(ful_sa), 0);
    step(1, 0, 8'h44, 0);
    chk("w4_usedw", 32'(uw_sa), 4);
    chk("w4_full", 32'(ful_sa), 1);

    // Read+write while full
    step(1, 1, 8'h55, 0);
    chk("rw_full_usedw", 32'(uw_sa), 4);
    chk("rw_full_full", 32'(ful_sa), 1);
    chk("rw_full_q_sa", 32'(q_sa), 'h22);
    chk("rw_full_q_rg", 32'(q_rg), 'h11);

    // Drain
    step(0, 1, 8'h00, 0);
    chk("d1_q_rg", 32'(q_rg), 'h22);
    step(0, 1, 8'h00, 0);
    chk("d2_q_rg", 32'(q_rg), 'h33);
    step(0, 1, 8'h00, 0);
    chk("d3_q_rg", 32'(q_rg), 'h44);
    chk("d3_q_sa", 32'(q_sa), 'h55);
    step(0, 1, 8'h00, 0);
    chk("d4_q_rg", 32'(q_rg), 'h55);
    chk("d4_empty", 32'(emp_sa), 1);

    // Read+write while empty: read ignored
    step(1, 1, 8'hA5, 0);
    chk("rw_empty_usedw", 32'(uw_sa), 1);
    chk("rw_empty_q_sa", 32'(q_sa), 'hA5);
    chk("rw_empty_q_rg", 32'(q_rg), 'h55);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rw_empty_unf", 32'(unf_sa), 0);
`endif
    step(0, 1, 8'h00, 0);
    chk("rdA5_q_rg", 32'(q_rg), 'hA5);

    // Registered mode: two words then an empty read
    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    step(0, 1, 8'h00, 0);
    chk("rg_first", 32'(q_rg), 'h01);
    step(0, 1, 8'h00, 0);
    chk("rg_second", 32'(q_rg), 'h02);
    step(0, 1, 8'h00, 0);
    chk("rg_empty_read", 32'(q_rg), 'h02);
`ifdef FIFO_ERR_FLAGS_EN
    chk("empty_read_unf", 32'(unf_sa), 1);
`endif

    // Fill then sclr with a concurrent write
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h61 + i), 0);
    chk("pre_clr_full", 32'(ful_sa), 1);
    step(1, 0, 8'h99, 1);
    chk("clr_usedw", 32'(uw_sa), 0);
    chk("clr_empty", 32'(emp_sa), 1);
    chk("clr_aempty", 32'(ae_sa), 1);
    chk("clr_full", 32'(ful_sa), 0);
    chk("clr_q_rg", 32'(q_rg), 0);
    step(1, 0, 8'h77, 0);
    chk("post_clr_q_sa", 32'(q_sa), 'h77);

    // Write while full without read, then asynchronous reset mid-stream
    step(1, 0, 8'h78, 0);
    step(1, 0, 8'h79, 0);
    step(1, 0, 8'h7A, 0);
    step(1, 0, 8'hEE, 0);
    chk("ovf_usedw", 32'(uw_sa), 4);
    chk("ovf_q_sa", 32'(q_sa), 'h77);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(ovf_sa), 1);
`endif
    step(0, 1, 8'h00, 0);
    chk("ovf_next_q_sa", 32'(q_sa), 'h78);
    wrreq = 1'b1; data = 8'h5A;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_usedw", 32'(uw_sa), 0);
    chk("arst_empty", 32'(emp_sa), 1);
    chk("arst_rg_usedw", 32'(uw_rg), 0);
    chk("arst_q_rg", 32'(q_rg), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("arst_ovf", 32'(ovf_sa), 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    wrreq = 1'b0;

    // Mixed traffic across pointer wrap, checked against the model each cycle
    for (int i = 0; i < 40; i++)
      step(i % 3 != 0, (i % 4 == 1) || (i % 4 == 2), 8'(i * 13 + 5), i == 25);

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
